// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants, types and the prefix next-state function
// for the time-multiplexed serial pattern detector.
//   DEF_PLEN / DEF_PATTERN : default pattern 0110 (first received bit is MSB)
//   prefix_t               : partial-match length, 0..8
//   next_prefix()          : overlapping next-state for one received bit
package seq_detect_pkg;

  localparam int             DEF_PLEN    = 4;
  localparam logic [3:0]     DEF_PATTERN = 4'b0110;

  typedef logic [3:0] prefix_t;

  // Appends bit b to the first min(l,plen) pattern bits and returns the
  // longest k <= plen such that the last k bits equal the first k pattern
  // bits. Starting from l == plen keeps the overlap alive for the next match.
  function automatic prefix_t next_prefix(input logic [7:0] pattern,
                                          input int         plen,
                                          input prefix_t    l,
                                          input logic       b);
    logic [8:0] s;
    logic [7:0] p;
    int         m;
    logic       ok;
    prefix_t    res;
    s   = '0;
    p   = '0;
    res = '0;
    m   = (int'(l) < plen) ? int'(l) : plen;
    // p[j] is the j-th pattern bit in arrival order
    for (int j = 0; j < 8; j++)
      if (j < plen) p[j] = pattern[plen-1-j];
    for (int j = 0; j < 8; j++)
      if (j < m) s[j] = p[j];
    s[m] = b;
    for (int k = 1; k <= 8; k++) begin
      if (k <= plen && k <= m + 1) begin
        ok = 1'b1;
        for (int j = 0; j < 8; j++)
          if (j < k && s[m+1-k+j] != p[j]) ok = 1'b0;
        if (ok) res = prefix_t'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant, searching upward from ptr with wrap.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when nothing requests)
//   idx : index of the granted request (0 when nothing requests)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int c;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: CH serial channels share one overlapping pattern engine.
// A round-robin arbiter accepts at most one bit per cycle; each channel's
// partial-match length is saved in ctx[] and restored when it is granted.
//   clk, reset          : clock, async active-high reset
//   ch_enable           : per-channel enable (disabled => context cleared)
//   bit_valid / bit_in  : per-channel serial offer and data
//   bit_ready           : one-hot grant
//   match_valid/match_ch: one-cycle match pulse and owning channel
//   cnt_clr             : per-channel synchronous counter clear
//   rd_sel / rd_cnt     : counter readout mux
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int              CH      = 4,
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  parameter int              CNTW    = 8,
  localparam int             IW      = $clog2(CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   ch_enable,
  input  logic [CH-1:0]   bit_valid,
  input  logic [CH-1:0]   bit_in,
  output logic [CH-1:0]   bit_ready,
  output logic            match_valid,
  output logic [IW-1:0]   match_ch,
  input  logic [CH-1:0]   cnt_clr,
  input  logic [IW-1:0]   rd_sel,
  output logic [CNTW-1:0] rd_cnt
);

  prefix_t         ctx [CH];
  logic [CNTW-1:0] cnt [CH];
  logic [IW-1:0]   rr_ptr;
  logic [CH-1:0]   gnt;
  logic [IW-1:0]   gidx;
  logic            xfer;
  prefix_t         new_l;
  logic            hit;

  rr_arbiter #(.N(CH), .IW(IW)) u_arb (
    .req (bit_valid & ch_enable),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign bit_ready = gnt;
  assign xfer      = |gnt;
  assign new_l     = next_prefix(8'(PATTERN), PLEN, ctx[gidx], bit_in[gidx]);
  assign hit       = xfer && (int'(new_l) == PLEN);
  assign rd_cnt    = (int'(rd_sel) < CH) ? cnt[rd_sel] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      for (int i = 0; i < CH; i++) begin
        ctx[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gidx;
      if (xfer) rr_ptr <= (int'(gidx) == CH - 1) ? '0 : IW'(int'(gidx) + 1);
      for (int i = 0; i < CH; i++) begin
        if (!ch_enable[i])
          ctx[i] <= '0;
        else if (xfer && int'(gidx) == i)
          ctx[i] <= new_l;
        // clear takes priority over a same-cycle increment
        if (cnt_clr[i])
          cnt[i] <= '0;
        else if (hit && int'(gidx) == i && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed self-checking bench for seq_detect_sched
// (CH=4, pattern 0110, 2-bit counters so saturation is reachable).
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ch_enable, bit_valid, bit_in, bit_ready, cnt_clr;
  logic       match_valid;
  logic [1:0] match_ch, rd_sel, rd_cnt;

  int total = 0;
  int bad   = 0;
  logic seq4 [4];

  seq_detect_sched #(.CH(4), .PLEN(4), .PATTERN(4'b0110), .CNTW(2)) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .bit_valid(bit_valid),
    .bit_in(bit_in), .bit_ready(bit_ready), .match_valid(match_valid),
    .match_ch(match_ch), .cnt_clr(cnt_clr), .rd_sel(rd_sel), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    bit_valid = '0;
    cnt_clr   = '0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  // one bit on a single valid channel; checks grant and match pulse
  task automatic send(input int ch, input logic b, input logic exp_mv, input string tag);
    bit_valid = 4'(1 << ch);
    bit_in    = b ? 4'b1111 : 4'b0000;
    #1;
    chk({tag, "_rdy"}, 32'(bit_ready), 32'(1 << ch));
    tick();
    chk({tag, "_mv"}, 32'(match_valid), 32'(exp_mv));
    if (exp_mv) chk({tag, "_ch"}, 32'(match_ch), 32'(ch));
    bit_valid = '0;
  endtask

  initial begin
    logic [3:0] exp_rdy [5];
    seq4 = '{1'b0, 1'b1, 1'b1, 1'b0};
    reset = 1'b1; ch_enable = '0; bit_valid = '0; bit_in = '0;
    cnt_clr = '0; rd_sel = '0;
    #2;
    chk("rst_mv", 32'(match_valid), 32'd0);
    chk("rst_ch", 32'(match_ch), 32'd0);
    chk("rst_rdy", 32'(bit_ready), 32'd0);
    chk("rst_cnt", 32'(rd_cnt), 32'd0);
    tick();
    reset = 1'b0;

    // single channel, stream 0110110
    ch_enable = 4'b0001;
    send(0, 0, 0, "t1b1"); send(0, 1, 0, "t1b2"); send(0, 1, 0, "t1b3");
    send(0, 0, 1, "t1b4"); send(0, 1, 0, "t1b5"); send(0, 1, 0, "t1b6");
    send(0, 0, 1, "t1b7");
    tick();
    chk("t1_idle_mv", 32'(match_valid), 32'd0);
    chk("t1_ch_hold", 32'(match_ch), 32'd0);
    rd_sel = 2'd0; #1;
    chk("t1_cnt0", 32'(rd_cnt), 32'd2);

    // two interleaved channels, both streaming 0110
    reset_pulse();
    ch_enable = 4'b0011;
    bit_valid = 4'b0011;
    for (int t = 0; t < 8; t++) begin
      bit_in = seq4[t/2] ? 4'b1111 : 4'b0000;
      #1;
      chk("t2_rdy", 32'(bit_ready), 32'(1 << (t % 2)));
      tick();
      chk("t2_mv", 32'(match_valid), 32'((t == 6) || (t == 7)));
      if (t >= 6) chk("t2_ch", 32'(match_ch), 32'(t % 2));
    end
    bit_valid = '0;
    rd_sel = 2'd0; #1; chk("t2_cnt0", 32'(rd_cnt), 32'd1);
    rd_sel = 2'd1; #1; chk("t2_cnt1", 32'(rd_cnt), 32'd1);

    // four channels round robin, then channel 2 drops out
    reset_pulse();
    ch_enable = 4'b1111;
    bit_valid = 4'b1111;
    bit_in    = 4'b0000;
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int t = 0; t < 5; t++) begin
      #1; chk("t3_rr", 32'(bit_ready), 32'(exp_rdy[t])); tick();
    end
    bit_valid = 4'b1011;
    exp_rdy = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    for (int t = 0; t < 5; t++) begin
      #1; chk("t3_skip", 32'(bit_ready), 32'(exp_rdy[t])); tick();
    end
    bit_valid = '0;

    // disabled channel is never granted; re-enabled channel starts clean
    reset_pulse();
    ch_enable = 4'b1101;
    bit_valid = 4'b0010;
    bit_in    = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      #1; chk("t4_dis_rdy", 32'(bit_ready), 32'd0); tick();
      chk("t4_dis_mv", 32'(match_valid), 32'd0);
    end
    ch_enable = 4'b1111;
    send(1, 1, 0, "t4a"); send(1, 1, 0, "t4b"); send(1, 0, 0, "t4c");
    send(1, 0, 0, "t4d"); send(1, 1, 0, "t4e"); send(1, 1, 0, "t4f");
    send(1, 0, 1, "t4g");

    // enable dropping mid-pattern clears that channel's context
    reset_pulse();
    ch_enable = 4'b0001;
    send(0, 0, 0, "t5a"); send(0, 1, 0, "t5b"); send(0, 1, 0, "t5c");
    ch_enable = 4'b0000;
    tick();
    chk("t5_ctx", 32'(dut.ctx[0]), 32'd0);
    ch_enable = 4'b0001;
    send(0, 0, 0, "t5d");

    // async reset cancels a pending pulse
    reset_pulse();
    ch_enable = 4'b0001;
    send(0, 0, 0, "t6a"); send(0, 1, 0, "t6b"); send(0, 1, 0, "t6c");
    send(0, 0, 1, "t6d");
    reset = 1'b1; #1;
    chk("t6_cancel", 32'(match_valid), 32'd0);
    tick();
    reset = 1'b0;

    // reset mid-pattern loses context and counters
    send(0, 0, 0, "t7a"); send(0, 1, 0, "t7b"); send(0, 1, 0, "t7c");
    reset_pulse();
    send(0, 0, 0, "t7d");
    chk("t7_ctx", 32'(dut.ctx[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1; chk("t7_cnt", 32'(rd_cnt), 32'd0);
    end

    // saturation at 3, then clear beats a same-cycle increment
    reset_pulse();
    ch_enable = 4'b0001;
    send(0, 0, 0, "t8a"); send(0, 1, 0, "t8b"); send(0, 1, 0, "t8c");
    send(0, 0, 1, "t8d");
    for (int n = 0; n < 4; n++) begin
      send(0, 1, 0, "t8e"); send(0, 1, 0, "t8f"); send(0, 0, 1, "t8g");
    end
    rd_sel = 2'd0; #1;
    chk("t8_sat", 32'(rd_cnt), 32'd3);
    send(0, 1, 0, "t8h"); send(0, 1, 0, "t8i");
    cnt_clr = 4'b0001;
    send(0, 0, 1, "t8j");
    cnt_clr = 4'b0000;
    #1;
    chk("t8_clr", 32'(rd_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
